truth_table_scanner: RTL and testbench

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

---
 rtl/truth_table_scanner.sv | 134 +++++++++++++
 tb/tb_truth_table_scanner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: drives all eight 3-bit vectors to a downstream
// combinational circuit, holding each for HOLD_CYCLES clocks, and captures
// the returned Y into an 8-bit truth table.
// Optional feature macro: SCAN_COMPARE_EN (compare captured table against
// the golden table latched at start and raise mismatch at scan end).
module truth_table_scanner #(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       Y,
    input  logic [7:0] expected,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic [2:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic       mismatch
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] hold_q, hold_d;
    logic [7:0] tt_q, tt_d;
    logic       accept;

`ifdef SCAN_COMPARE_EN
    logic [7:0] exp_q, exp_d;
    logic       mismatch_q, mismatch_d;
`else
    logic       unused_expected;
    assign unused_expected = ^expected;
`endif

    // A new scan is accepted from IDLE, or straight out of DONE so that a
    // continuously held start yields back-to-back scans.
    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    // Next-state: sequence vectors, sample Y on the last hold cycle of each.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        tt_d    = tt_q;
`ifdef SCAN_COMPARE_EN
        exp_d      = exp_q;
        mismatch_d = mismatch_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            DRIVE: begin
                if (hold_q == HOLD_LAST) begin
                    tt_d[idx_q] = Y;
                    hold_d      = '0;
                    if (idx_q == 3'd7) begin
                        state_d = DONE;
`ifdef SCAN_COMPARE_EN
                        mismatch_d = (tt_d != exp_q);
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (accept) begin
            state_d = DRIVE;
            idx_d   = '0;
            hold_d  = '0;
            tt_d    = '0;
`ifdef SCAN_COMPARE_EN
            exp_d      = expected;
            mismatch_d = 1'b0;
`endif
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            tt_q    <= '0;
`ifdef SCAN_COMPARE_EN
            exp_q      <= '0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            tt_q    <= tt_d;
`ifdef SCAN_COMPARE_EN
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

    assign busy      = (state_q == DRIVE);
    assign done      = (state_q == DONE);
    assign vec_idx   = busy ? idx_q : '0;
    assign {A, B, C} = busy ? idx_q : '0;
    assign tt        = tt_q;

`ifdef SCAN_COMPARE_EN
    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: one instance with HOLD_CYCLES=2 driving
// Y=(A&B)|C, one with HOLD_CYCLES=1 driving Y=A^B^C.
module tb_truth_table_scanner;

    logic       clk = 1'b0;
    logic       rst, start, start1;
    logic [7:0] exp_in;

    logic       a2, b2, c2, busy2, done2, mm2, y2;
    logic [2:0] vi2;
    logic [7:0] tt2;
    logic       a1, b1, c1, busy1, done1, mm1, y1;
    logic [2:0] vi1;
    logic [7:0] tt1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    assign y2 = (a2 & b2) | c2;
    assign y1 = a1 ^ b1 ^ c1;

    truth_table_scanner #(.HOLD_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .Y(y2), .expected(exp_in),
        .A(a2), .B(b2), .C(c2), .vec_idx(vi2), .busy(busy2), .done(done2),
        .tt(tt2), .mismatch(mm2)
    );

    truth_table_scanner #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .Y(y1), .expected(8'h96),
        .A(a1), .B(b1), .C(c1), .vec_idx(vi1), .busy(busy1), .done(done1),
        .tt(tt1), .mismatch(mm1)
    );

    function automatic logic [7:0] model_tt(input int mode);
        logic [7:0] r;
        logic       a, b, c;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            a = k[2]; b = k[1]; c = k[0];
            r[k] = (mode == 0) ? ((a & b) | c) : (a ^ b ^ c);
        end
        return r;
    endfunction

    function automatic logic mm_model(input logic [7:0] t, input logic [7:0] e);
`ifdef SCAN_COMPARE_EN
        return t != e;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
        end else begin
            e = sb.pop_front();
            chk(tag, 32'(obs), 32'(e));
        end
    endtask

    // Full HOLD_CYCLES=2 scan with per-cycle checks; optional re-start pulse.
    task automatic scan2(input int restart_at);
        logic [7:0] t;
        logic       mm_e;
        t    = model_tt(0);
        mm_e = mm_model(t, exp_in);
        @(negedge clk);
        start = 1'b1;
        sb.push_back(t);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) @(negedge clk);
            if (c < 16) begin
                chk("busy", 32'(busy2), 32'd1);
                chk("done_low", 32'(done2), 32'd0);
                chk("abc", 32'({a2, b2, c2}), 32'(c / 2));
                chk("vec_idx", 32'(vi2), 32'(c / 2));
                if (c == 0) begin
                    chk("tt_cleared", 32'(tt2), 32'd0);
                    chk("mm_cleared", 32'(mm2), 32'd0);
                end
            end else begin
                chk("done", 32'(done2), 32'd1);
                chk("busy_done", 32'(busy2), 32'd0);
                chk("abc_done", 32'({a2, b2, c2}), 32'd0);
                pop_chk("tt", tt2);
                chk("mismatch", 32'(mm2), 32'(mm_e));
            end
            start = (c == restart_at);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("tt_hold", 32'(tt2), 32'(t));
        chk("mm_hold", 32'(mm2), 32'(mm_e));
        chk("done_pulse", 32'(done2), 32'd0);
        chk("idle_busy", 32'(busy2), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        exp_in = 8'hEA;
        repeat (2) @(negedge clk);
        start  = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_done", 32'(done2), 32'd0);
        chk("rst_tt", 32'(tt2), 32'd0);
        chk("rst_abc", 32'({a2, b2, c2, vi2}), 32'd0);
        chk("rst_mm", 32'(mm2), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        rst    = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;

        // Plain scan, and golden constant cross-check.
        scan2(-1);
        chk("tt_EA", 32'(tt2), 32'h0EA);

        // HOLD_CYCLES=1 scan.
        @(negedge clk);
        start1 = 1'b1;
        sb.push_back(model_tt(1));
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) @(negedge clk);
            chk("h1_busy", 32'(busy1), 32'(c < 8));
            chk("h1_done", 32'(done1), 32'(c == 8));
            chk("h1_abc", 32'({a1, b1, c1}), (c < 8) ? 32'(c) : 32'd0);
            if (c == 8) begin
                pop_chk("h1_tt", tt1);
                chk("h1_tt96", 32'(tt1), 32'h096);
            end
        end

        // Re-start pulse mid-scan is ignored.
        scan2(5);

        // Reset at cycle 7 of a scan.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_tt", 32'(tt2), 32'(model_tt(0) & 8'h07));
        chk("pre_rst_busy", 32'(busy2), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy2), 32'd0);
        chk("mid_rst_tt", 32'(tt2), 32'd0);
        chk("mid_rst_abc", 32'({a2, b2, c2, vi2}), 32'd0);
        chk("mid_rst_done", 32'(done2), 32'd0);
        scan2(-1);

        // Golden table differs in bit 0.
        exp_in = 8'hEB;
        scan2(-1);
        exp_in = 8'hEA;

        // Start held high: back-to-back scans.
        @(negedge clk);
        start = 1'b1;
        sb.push_back(model_tt(0));
        sb.push_back(model_tt(0));
        for (int c = 0; c <= 33; c++) begin
            @(negedge clk);
            if (c == 16 || c == 33) begin
                chk("b2b_done", 32'(done2), 32'd1);
                chk("b2b_busy_done", 32'(busy2), 32'd0);
                pop_chk("b2b_tt", tt2);
            end else begin
                chk("b2b_busy", 32'(busy2), 32'd1);
                chk("b2b_done_low", 32'(done2), 32'd0);
            end
            if (c == 17) chk("b2b_tt_clr", 32'(tt2), 32'd0);
            if (c == 33) start = 1'b0;
        end
        @(negedge clk);
        chk("b2b_idle", 32'(busy2), 32'd0);
        chk("b2b_tt_hold", 32'(tt2), 32'h0EA);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
